// File: rtl/irq_ctrl.sv
// Eight-line priority interrupt controller: rising-edge latching into pending,
// maskable, with a single outstanding request/service handshake (no nesting).
module irq_ctrl (
  input  logic       clk,
  input  logic       rstN,
  input  logic [7:0] irq_in,
  input  logic       mask_we,
  input  logic [7:0] mask_wdata,
  input  logic [7:0] status,
  input  logic       irq_ack,
  input  logic       eoi,
  output logic       irq_req,
  output logic [2:0] irq_vec,
  output logic [7:0] pending,
  output logic [7:0] in_service,
  output logic [7:0] overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    SERVICE = 2'b10
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] prev;
  logic [7:0] mask;
  logic [7:0] edges;
  logic [7:0] eligible;
  logic [7:0] ack_clear;
  logic [7:0] pending_next;
  logic [7:0] overrun_next;
  logic [7:0] in_service_next;
  logic       irq_req_next;
  logic [2:0] irq_vec_next;

  function automatic logic [2:0] top_index(input logic [7:0] bits);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bits[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state      <= IDLE;
      prev       <= 8'h00;
      mask       <= 8'hFF;
      pending    <= 8'h00;
      overrun    <= 8'h00;
      in_service <= 8'h00;
      irq_req    <= 1'b0;
      irq_vec    <= 3'd0;
    end else begin
      state      <= state_next;
      prev       <= irq_in;
      if (mask_we) mask <= mask_wdata;
      pending    <= pending_next;
      overrun    <= overrun_next;
      in_service <= in_service_next;
      irq_req    <= irq_req_next;
      irq_vec    <= irq_vec_next;
    end
  end

  // A new edge on the line being acknowledged re-sets pending and is not an overrun.
  always_comb begin
    edges           = irq_in & ~prev;
    eligible        = pending & ~mask;
    state_next      = state;
    ack_clear       = 8'h00;
    irq_req_next    = irq_req;
    irq_vec_next    = irq_vec;
    in_service_next = in_service;
    case (state)
      IDLE: begin
        if (status[7] && (eligible != 8'h00)) begin
          state_next   = REQ;
          irq_req_next = 1'b1;
          irq_vec_next = top_index(eligible);
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_next      = SERVICE;
          irq_req_next    = 1'b0;
          ack_clear       = 8'h01 << irq_vec;
          in_service_next = 8'h01 << irq_vec;
        end
      end
      SERVICE: begin
        if (eoi) begin
          state_next      = IDLE;
          in_service_next = 8'h00;
        end
      end
      default: state_next = IDLE;
    endcase
    pending_next = (pending & ~ack_clear) | edges;
    overrun_next = overrun | (edges & pending & ~ack_clear);
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl: inputs change 1ns after each
// rising edge, outputs are checked at that same point.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rstN;
  logic [7:0] irq_in;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic [7:0] status;
  logic       irq_ack;
  logic       eoi;
  logic       irq_req;
  logic [2:0] irq_vec;
  logic [7:0] pending;
  logic [7:0] in_service;
  logic [7:0] overrun;

  int compared   = 0;
  int mismatched = 0;

  irq_ctrl dut (
    .clk        (clk),
    .rstN       (rstN),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .status     (status),
    .irq_ack    (irq_ack),
    .eoi        (eoi),
    .irq_req    (irq_req),
    .irq_vec    (irq_vec),
    .pending    (pending),
    .in_service (in_service),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] lines);
    irq_in = lines;
    tick();
    irq_in = 8'h00;
  endtask

  task automatic writeMask(input logic [7:0] value);
    mask_we    = 1'b1;
    mask_wdata = value;
    tick();
    mask_we    = 1'b0;
  endtask

  initial begin
    rstN = 1'b0; irq_in = 8'h00; mask_we = 1'b0; mask_wdata = 8'h00;
    status = 8'h00; irq_ack = 1'b0; eoi = 1'b0;
    tick(2);
    rstN = 1'b1;
    checkOutput("rst_pending", pending, 8'h00);
    checkOutput("rst_req", {7'b0, irq_req}, 8'h00);
    checkOutput("rst_vec", {5'b0, irq_vec}, 8'h00);
    checkOutput("rst_isr", in_service, 8'h00);
    checkOutput("rst_ovr", overrun, 8'h00);

    // Basic request, eoi-outside-service ignored, ack and eoi
    writeMask(8'h00);
    status = 8'h80;
    applyStimulus(8'h08);
    checkOutput("basic_pending", pending, 8'h08);
    checkOutput("basic_req_early", {7'b0, irq_req}, 8'h00);
    tick();
    checkOutput("basic_req", {7'b0, irq_req}, 8'h01);
    checkOutput("basic_vec", {5'b0, irq_vec}, 8'h03);
    eoi = 1'b1; tick(); eoi = 1'b0;
    checkOutput("eoi_in_req_ignored", {7'b0, irq_req}, 8'h01);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    checkOutput("ack_pending", pending, 8'h00);
    checkOutput("ack_isr", in_service, 8'h08);
    checkOutput("ack_req", {7'b0, irq_req}, 8'h00);
    eoi = 1'b1; tick(); eoi = 1'b0;
    checkOutput("eoi_isr", in_service, 8'h00);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    checkOutput("ack_in_idle_ignored", in_service, 8'h00);
    checkOutput("idle_vec_kept", {5'b0, irq_vec}, 8'h03);

    // Priority between simultaneous edges, then reassertion after eoi
    applyStimulus(8'h44);
    checkOutput("prio_pending", pending, 8'h44);
    tick();
    checkOutput("prio_vec_hi", {5'b0, irq_vec}, 8'h06);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    checkOutput("prio_isr", in_service, 8'h40);
    checkOutput("prio_pending_after_ack", pending, 8'h04);
    eoi = 1'b1; tick(); eoi = 1'b0;
    checkOutput("prio_req_gap", {7'b0, irq_req}, 8'h00);
    tick();
    checkOutput("prio_req_again", {7'b0, irq_req}, 8'h01);
    checkOutput("prio_vec_lo", {5'b0, irq_vec}, 8'h02);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;

    // Gating by mask and by status[7]
    writeMask(8'hFF);
    applyStimulus(8'h20);
    tick(2);
    checkOutput("gate_pending", pending, 8'h20);
    checkOutput("gate_mask_req", {7'b0, irq_req}, 8'h00);
    status = 8'h00;
    writeMask(8'h00);
    tick(2);
    checkOutput("gate_status_req", {7'b0, irq_req}, 8'h00);
    status = 8'h80;
    tick();
    checkOutput("gate_open_req", {7'b0, irq_req}, 8'h01);
    checkOutput("gate_open_vec", {5'b0, irq_vec}, 8'h05);
    status = 8'h00;
    tick();
    checkOutput("status_off_keeps_req", {7'b0, irq_req}, 8'h01);
    status = 8'h80;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;

    // Edge coinciding with ack: set wins, no overrun
    applyStimulus(8'h02);
    tick();
    checkOutput("coll_vec", {5'b0, irq_vec}, 8'h01);
    irq_in = 8'h02; irq_ack = 1'b1; tick(); irq_ack = 1'b0; irq_in = 8'h00;
    checkOutput("coll_pending", pending, 8'h02);
    checkOutput("coll_overrun", overrun, 8'h00);
    checkOutput("coll_isr", in_service, 8'h02);
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    checkOutput("coll_req_again", {7'b0, irq_req}, 8'h01);

    // Second edge while pending gives overrun; higher edge does not replace vec
    applyStimulus(8'h02);
    checkOutput("ovr_set", overrun, 8'h02);
    applyStimulus(8'h80);
    tick();
    checkOutput("ovr_vec_held", {5'b0, irq_vec}, 8'h01);
    checkOutput("ovr_pending", pending, 8'h82);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    checkOutput("svc_isr", in_service, 8'h02);

    // Reset in SERVICE abandons transaction and re-masks all lines
    rstN = 1'b0; tick(); rstN = 1'b1;
    checkOutput("rst2_pending", pending, 8'h00);
    checkOutput("rst2_isr", in_service, 8'h00);
    checkOutput("rst2_ovr", overrun, 8'h00);
    checkOutput("rst2_req", {7'b0, irq_req}, 8'h00);
    checkOutput("rst2_vec", {5'b0, irq_vec}, 8'h00);
    applyStimulus(8'h10);
    tick(2);
    checkOutput("rst2_masked_pending", pending, 8'h10);
    checkOutput("rst2_masked_req", {7'b0, irq_req}, 8'h00);

    // Line held high across reset release registers one edge
    irq_in = 8'h01;
    rstN = 1'b0; tick(); rstN = 1'b1;
    tick();
    checkOutput("held_edge_pending", pending, 8'h01);
    tick();
    checkOutput("held_no_ovr", overrun, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
